alu_pipe: RTL



---
 rtl/alu_pipe_pkg.sv | 45 ++++
 rtl/alu_slice.sv | 70 +++++++
 rtl/alu_pipe.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/alu_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe_pkg
//  Purpose  : Shared opcode enumerations, FSM state codes and sizing helper
//             for the sliced multi-cycle ALU.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pipe_pkg;

  // Arithmetic opcodes (mode = 1)
  typedef enum logic [2:0] {
    A_ADD  = 3'b000,
    A_ADC  = 3'b001,
    A_SUB  = 3'b010,
    A_SBB  = 3'b011,
    A_INC  = 3'b100,
    A_SHL1 = 3'b101,
    A_DEC  = 3'b110,
    A_CMP  = 3'b111
  } arith_op_e;

  // Logic opcodes (mode = 0)
  typedef enum logic [2:0] {
    L_AND  = 3'b000,
    L_OR   = 3'b001,
    L_XOR  = 3'b010,
    L_NOR  = 3'b011,
    L_NOT  = 3'b100,
    L_PASS = 3'b101,
    L_NAND = 3'b110,
    L_XNOR = 3'b111
  } logic_op_e;

  // FSM state codes
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Number of slices needed to cover a full operand
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_slice.sv
`default_nettype none
// ============================================================================
//  Module   : alu_slice
//  Purpose  : Purely combinational CHUNK-bit ALU slice. The B operand and the
//             carry-in convention are derived from the opcode; cout/ovf are
//             meaningful at the slice MSB, which matters for the top slice.
//  Revision : 1.0  initial release
// ============================================================================
module alu_slice
  import alu_pipe_pkg::*;
#(
  parameter int CHUNK = 32
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             mode,
  input  logic [2:0]       operation,
  input  logic             cin,
  output logic [CHUNK-1:0] r,
  output logic             cout,
  output logic             ovf,
  output logic             is_zero
);

  logic [CHUNK-1:0] w_bsel;
  logic [CHUNK:0]   w_sum;

  // Select the effective B operand, add, and form result/carry/overflow
  always_comb begin
    w_bsel = '0;
    w_sum  = '0;
    r      = '0;
    cout   = 1'b0;
    ovf    = 1'b0;
    if (mode) begin
      case (operation)
        A_ADD, A_ADC:        w_bsel = b;
        A_SUB, A_SBB, A_CMP: w_bsel = ~b;
        A_DEC:               w_bsel = '1;
        default:             w_bsel = '0;
      endcase
      w_sum = {1'b0, a} + {1'b0, w_bsel} + {{CHUNK{1'b0}}, cin};
      if (operation == A_SHL1) begin
        // cin carries the MSB of the previous slice into bit 0
        r    = {a[CHUNK-2:0], cin};
        cout = a[CHUNK-1];
        ovf  = a[CHUNK-1] ^ a[CHUNK-2];
      end else begin
        r    = w_sum[CHUNK-1:0];
        cout = w_sum[CHUNK];
        ovf  = (a[CHUNK-1] ~^ w_bsel[CHUNK-1]) & (w_sum[CHUNK-1] ^ a[CHUNK-1]);
      end
    end else begin
      case (operation)
        L_AND:   r = a & b;
        L_OR:    r = a | b;
        L_XOR:   r = a ^ b;
        L_NOR:   r = ~(a | b);
        L_NOT:   r = ~a;
        L_PASS:  r = b;
        L_NAND:  r = ~(a & b);
        default: r = ~(a ^ b);
      endcase
    end
  end

  assign is_zero = (r == '0);

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe
//  Purpose  : Multi-cycle WIDTH-bit ALU processing one CHUNK-bit slice per
//             clock, with valid/ready handshakes, registered flags and a
//             sticky carry (cy_s) for ADC/SBB chaining across operations.
//  Revision : 1.0  initial release
// ============================================================================
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int CHUNK = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             mode,
  input  logic [2:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             sign_flag,
  output logic             overflow_flag
);

  localparam int              NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int              IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST   = IDXW'(NCHUNK - 1);

  // Configuration guard: slices must tile the operand exactly, and SHL1
  // overflow needs at least two bits per slice.
  if (((WIDTH % CHUNK) != 0) || (CHUNK < 2)) begin : g_bad_cfg
    $error("alu_pipe: WIDTH must be a multiple of CHUNK and CHUNK >= 2");
  end

  logic [1:0]       r_state;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_op1, r_op2;
  logic             r_mode;
  logic [2:0]       r_operation;
  logic             r_carry;
  logic             r_zacc;
  logic             r_cys;
  logic [WIDTH-1:0] r_out;
  logic             r_cf, r_zf, r_sf, r_vf;

  logic [CHUNK-1:0] w_a, w_b, w_r, w_slice_out;
  logic             w_cin, w_cout, w_ovf, w_is_zero;
  logic             w_last, w_accept;

  assign in_ready      = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign out_valid     = (r_state == S_DONE);
  assign w_accept      = in_valid & in_ready;
  assign w_last        = (r_idx == LAST);
  assign out           = r_out;
  assign carry_flag    = r_cf;
  assign zero_flag     = r_zf;
  assign sign_flag     = r_sf;
  assign overflow_flag = r_vf;

  // Pick the operand slices addressed by the current slice index
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_a = r_op1[k*CHUNK +: CHUNK];
        w_b = r_op2[k*CHUNK +: CHUNK];
      end
    end
  end

  // Slice 0 takes its carry from the opcode; later slices chain r_carry
  always_comb begin
    w_cin = r_carry;
    if (r_idx == '0) begin
      case (r_operation)
        A_ADC, A_SBB:        w_cin = r_cys;
        A_SUB, A_INC, A_CMP: w_cin = 1'b1;
        default:             w_cin = 1'b0;
      endcase
      if (!r_mode) w_cin = 1'b0;
    end
  end

  alu_slice #(.CHUNK(CHUNK)) u_slice (
    .a         (w_a),
    .b         (w_b),
    .mode      (r_mode),
    .operation (r_operation),
    .cin       (w_cin),
    .r         (w_r),
    .cout      (w_cout),
    .ovf       (w_ovf),
    .is_zero   (w_is_zero)
  );

  // CMP reports the subtraction in the flags but returns op1 unchanged
  assign w_slice_out = (r_mode && (r_operation == A_CMP)) ? w_a : w_r;

  // Handshake FSM, slice sequencing, result/flag registers and sticky carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_mode      <= 1'b0;
      r_operation <= '0;
      r_carry     <= 1'b0;
      r_zacc      <= 1'b0;
      r_cys       <= 1'b0;
      r_out       <= '0;
      r_cf        <= 1'b0;
      r_zf        <= 1'b0;
      r_sf        <= 1'b0;
      r_vf        <= 1'b0;
    end else if (r_state == S_BUSY) begin
      for (int k = 0; k < NCHUNK; k++) begin
        if (r_idx == IDXW'(k)) r_out[k*CHUNK +: CHUNK] <= w_slice_out;
      end
      r_carry <= w_cout;
      r_zacc  <= r_zacc & w_is_zero;
      if (w_last) begin
        r_cf    <= w_cout;
        r_vf    <= w_ovf;
        r_sf    <= w_r[CHUNK-1];
        r_zf    <= r_zacc & w_is_zero;
        if (r_mode) r_cys <= w_cout;
        r_idx   <= '0;
        r_state <= S_DONE;
      end else begin
        r_idx <= r_idx + IDXW'(1);
      end
    end else if (w_accept) begin
      // Accept from IDLE, or straight from DONE with no bubble
      r_op1       <= op1;
      r_op2       <= op2;
      r_mode      <= mode;
      r_operation <= operation;
      r_idx       <= '0;
      r_zacc      <= 1'b1;
      r_carry     <= 1'b0;
      r_state     <= S_BUSY;
    end else if ((r_state == S_DONE) && out_ready) begin
      r_state <= S_IDLE;
    end else if (r_state != S_DONE) begin
      r_state <= S_IDLE;
    end
  end

endmodule
`default_nettype wire
